ccmp_out_demux: RTL and testbench

- Return path of the CCMP engine: takes the single muxed CCMP output byte stream (data/valid/last) and steers each frame to either the TX path or the RX path.
- The CCMP engine has no backpressure, so a small FIFO absorbs destination stalls and exposes valid/ready handshakes per destination.
- Sits between the CCMP output mux and the TX FIFO writer / RX FIFO writer in the MAC core.

---
 rtl/ccmp_out_demux.sv | 194 +++++++++++++++++++
 tb/tb_ccmp_out_demux.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccmp_out_demux.sv
// CCMP output demultiplexer: per-frame TX/RX steering through a show-ahead FIFO.
// Optional per-destination byte counters are enabled with CCMP_OUT_DEMUX_BYTECNT_EN.
module ccmp_out_demux #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          macCoreClk,
    input  logic          macCoreClkSoftRst,
    input  logic          rxCsIsIdle,
    input  logic          nullKeyFound,
    input  logic [7:0]    ccmpOutDataMux,
    input  logic          ccmpOutValidMux_p,
    input  logic          ccmpOutLastMux_p,
    input  logic          frameAbort_p,
    input  logic          txReady,
    input  logic          rxReady,
    input  logic          errClr_p,
    output logic [7:0]    txData,
    output logic          txValid,
    output logic          txLast,
    output logic [7:0]    rxData,
    output logic          rxValid,
    output logic          rxLast,
    output logic          rxPlain,
    output logic [AW:0]   fifoLevel,
    output logic          overflowErr,
    output logic          frameBusy
`ifdef CCMP_OUT_DEMUX_BYTECNT_EN
    ,
    output logic [15:0]   txByteCnt,
    output logic [15:0]   rxByteCnt
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        INFRAME = 1'b1
    } state_t;

    // Entry layout {dir, plain, last, data}; dir = 1 means TX.
    localparam int EW = 11;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);

    state_t          state;
    state_t          stateNext;
    logic            frameDir;
    logic            framePlain;
    logic            pushDir;
    logic            pushPlain;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [AW:0]     level;
    logic [EW-1:0]   head;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            dropByte;

    assign empty    = (level == '0);
    assign full     = (level == LVL_FULL);
    assign head     = mem[rdPtr];

    assign txValid  = !empty && head[10];
    assign rxValid  = !empty && !head[10];
    assign pop      = (txValid && txReady) || (rxValid && rxReady);
    assign push     = ccmpOutValidMux_p && (!full || pop);
    assign dropByte = ccmpOutValidMux_p && full && !pop;

    assign txData    = empty ? '0 : head[7:0];
    assign rxData    = empty ? '0 : head[7:0];
    assign txLast    = txValid && head[8];
    assign rxLast    = rxValid && head[8];
    assign rxPlain   = rxValid && head[9];
    assign fifoLevel = level;
    assign frameBusy = (state == INFRAME);

    // The first byte of a frame takes routing straight from the inputs;
    // later bytes use the copy latched on that first byte.
    always_comb begin
        stateNext = state;
        pushDir   = frameDir;
        pushPlain = framePlain;
        unique case (state)
            IDLE: begin
                pushDir   = rxCsIsIdle;
                pushPlain = nullKeyFound;
                if (ccmpOutValidMux_p && !ccmpOutLastMux_p) begin
                    stateNext = INFRAME;
                end
            end
            INFRAME: begin
                if (ccmpOutValidMux_p && ccmpOutLastMux_p) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge macCoreClk) begin
        if (macCoreClkSoftRst) begin
            state      <= IDLE;
            frameDir   <= 1'b0;
            framePlain <= 1'b0;
        end else if (frameAbort_p) begin
            state      <= IDLE;
        end else begin
            state <= stateNext;
            if (state == IDLE && ccmpOutValidMux_p) begin
                frameDir   <= rxCsIsIdle;
                framePlain <= nullKeyFound;
            end
        end
    end

    always_ff @(posedge macCoreClk) begin
        if (macCoreClkSoftRst || frameAbort_p) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge macCoreClk) begin
        if (push && !frameAbort_p && !macCoreClkSoftRst) begin
            mem[wrPtr] <= {pushDir, pushPlain, ccmpOutLastMux_p, ccmpOutDataMux};
        end
    end

    // Set has priority over clear so a coincident overflow is never lost.
    always_ff @(posedge macCoreClk) begin
        if (macCoreClkSoftRst) begin
            overflowErr <= 1'b0;
        end else if (dropByte && !frameAbort_p) begin
            overflowErr <= 1'b1;
        end else if (errClr_p) begin
            overflowErr <= 1'b0;
        end
    end

`ifdef CCMP_OUT_DEMUX_BYTECNT_EN
    logic        txPop;
    logic        rxPop;
    logic        txClrPend;
    logic        rxClrPend;
    logic [15:0] txBase;
    logic [15:0] rxBase;

    assign txPop  = txValid && txReady;
    assign rxPop  = rxValid && rxReady;
    // A count stays visible for one cycle after its last byte, then restarts.
    assign txBase = txClrPend ? '0 : txByteCnt;
    assign rxBase = rxClrPend ? '0 : rxByteCnt;

    always_ff @(posedge macCoreClk) begin
        if (macCoreClkSoftRst || frameAbort_p) begin
            txByteCnt <= '0;
            rxByteCnt <= '0;
            txClrPend <= 1'b0;
            rxClrPend <= 1'b0;
        end else begin
            if (txPop) begin
                txByteCnt <= (txBase == 16'hFFFF) ? txBase : txBase + 16'd1;
            end else begin
                txByteCnt <= txBase;
            end
            if (rxPop) begin
                rxByteCnt <= (rxBase == 16'hFFFF) ? rxBase : rxBase + 16'd1;
            end else begin
                rxByteCnt <= rxBase;
            end
            txClrPend <= txPop && head[8];
            rxClrPend <= rxPop && head[8];
        end
    end
`endif

endmodule

// File: tb/tb_ccmp_out_demux.sv
// Self-checking bench for ccmp_out_demux: directed plan steps followed by random traffic,
// compared against a queue-based reference model of the frame demultiplexer.
module tb_ccmp_out_demux;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxCsIsIdle;
    logic          nullKeyFound;
    logic [7:0]    dIn;
    logic          vIn;
    logic          lIn;
    logic          abortIn;
    logic          txReady;
    logic          rxReady;
    logic          errClr;
    logic [7:0]    txData;
    logic          txValid;
    logic          txLast;
    logic [7:0]    rxData;
    logic          rxValid;
    logic          rxLast;
    logic          rxPlain;
    logic [AW:0]   fifoLevel;
    logic          overflowErr;
    logic          frameBusy;
`ifdef CCMP_OUT_DEMUX_BYTECNT_EN
    logic [15:0]   txByteCnt;
    logic [15:0]   rxByteCnt;
`endif

    always #5 clk = ~clk;

    ccmp_out_demux #(.DEPTH(DEPTH), .AW(AW)) dut (
        .macCoreClk        (clk),
        .macCoreClkSoftRst (rst),
        .rxCsIsIdle        (rxCsIsIdle),
        .nullKeyFound      (nullKeyFound),
        .ccmpOutDataMux    (dIn),
        .ccmpOutValidMux_p (vIn),
        .ccmpOutLastMux_p  (lIn),
        .frameAbort_p      (abortIn),
        .txReady           (txReady),
        .rxReady           (rxReady),
        .errClr_p          (errClr),
        .txData            (txData),
        .txValid           (txValid),
        .txLast            (txLast),
        .rxData            (rxData),
        .rxValid           (rxValid),
        .rxLast            (rxLast),
        .rxPlain           (rxPlain),
        .fifoLevel         (fifoLevel),
        .overflowErr       (overflowErr),
        .frameBusy         (frameBusy)
`ifdef CCMP_OUT_DEMUX_BYTECNT_EN
        ,
        .txByteCnt         (txByteCnt),
        .rxByteCnt         (rxByteCnt)
`endif
    );

    typedef struct {
        bit       isTx;
        bit       plain;
        bit       last;
        bit [7:0] data;
    } ent_t;

    ent_t q[$];
    bit   mInFrame;
    bit   mDir;
    bit   mPlain;
    bit   mOvf;
    int   mTxCnt;
    int   mRxCnt;
    bit   mTxDone;
    bit   mRxDone;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        bit expTx = (q.size() > 0) && q[0].isTx;
        bit expRx = (q.size() > 0) && !q[0].isTx;
        chk("txValid", txValid, expTx);
        chk("rxValid", rxValid, expRx);
        if (expTx) chk("txData", txData, q[0].data);
        if (expRx) chk("rxData", rxData, q[0].data);
        chk("txLast", txLast, expTx && q[0].last);
        chk("rxLast", rxLast, expRx && q[0].last);
        chk("rxPlain", rxPlain, expRx && q[0].plain);
        chk("fifoLevel", fifoLevel, q.size());
        chk("overflowErr", overflowErr, mOvf);
        chk("frameBusy", frameBusy, mInFrame);
`ifdef CCMP_OUT_DEMUX_BYTECNT_EN
        chk("txByteCnt", txByteCnt, mTxCnt);
        chk("rxByteCnt", rxByteCnt, mRxCnt);
`endif
    endtask

    function automatic void modelClear();
        q.delete();
        mInFrame = 0;
        mTxCnt   = 0;
        mRxCnt   = 0;
        mTxDone  = 0;
        mRxDone  = 0;
    endfunction

    // Byte count of the frame currently draining to one destination; shown for one
    // extra cycle after its last byte leaves, then back to zero.
    function automatic void countPop(input bit popped, input bit lastByte,
                                     inout int cnt, inout bit done);
        if (popped) begin
            cnt  = done ? 1 : ((cnt < 65535) ? cnt + 1 : 65535);
            done = lastByte;
        end else begin
            if (done) cnt = 0;
            done = 0;
        end
    endfunction

    function automatic void modelStep(input bit v, input bit l, input bit [7:0] d,
                                      input bit rc, input bit nk, input bit ab,
                                      input bit tr, input bit rr, input bit clr);
        bit   popped   = 0;
        bit   popTx    = 0;
        bit   popLast  = 0;
        bit   ovfSet;
        ent_t e;
        if (q.size() > 0) begin
            popTx   = q[0].isTx;
            popLast = q[0].last;
            popped  = popTx ? tr : rr;
        end
        if (ab) begin
            modelClear();
            if (clr) mOvf = 0;
            return;
        end
        ovfSet  = v && (q.size() == DEPTH) && !popped;
        e.isTx  = mInFrame ? mDir : rc;
        e.plain = mInFrame ? mPlain : nk;
        e.last  = l;
        e.data  = d;
        if (popped) void'(q.pop_front());
        if (v && !ovfSet) q.push_back(e);
        if (v) begin
            if (!mInFrame && !l) begin
                mInFrame = 1;
                mDir     = e.isTx;
                mPlain   = e.plain;
            end else if (mInFrame && l) begin
                mInFrame = 0;
            end
        end
        if (ovfSet) mOvf = 1;
        else if (clr) mOvf = 0;
        countPop(popped && popTx, popLast, mTxCnt, mTxDone);
        countPop(popped && !popTx, popLast, mRxCnt, mRxDone);
    endfunction

    task automatic cyc(input bit v, input bit l, input bit [7:0] d, input bit rc,
                       input bit nk, input bit ab, input bit tr, input bit rr,
                       input bit clr);
        vIn = v; lIn = l; dIn = d; rxCsIsIdle = rc; nullKeyFound = nk;
        abortIn = ab; txReady = tr; rxReady = rr; errClr = clr;
        @(posedge clk);
        modelStep(v, l, d, rc, nk, ab, tr, rr, clr);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n, input bit tr, input bit rr);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 0, 0, tr, rr, 0);
    endtask

    task automatic doReset();
        rst = 1; vIn = 0; lIn = 0; dIn = '0; rxCsIsIdle = 0; nullKeyFound = 0;
        abortIn = 0; txReady = 0; rxReady = 0; errClr = 0;
        repeat (2) @(posedge clk);
        #1;
        modelClear();
        mOvf = 0;
        chk("rstTxData", txData, 0);
        chk("rstRxData", rxData, 0);
        checkAll();
        rst = 0;
    endtask

    initial begin
        doReset();

        // TX frame A0..A3, sink always ready
        for (int i = 0; i < 4; i++) begin
            cyc(1, i == 3, 8'(8'hA0 + i), 1, 0, 0, 1, 0, 0);
            chk("t1TxValid", txValid, 1);
            chk("t1TxData", txData, 8'(8'hA0 + i));
        end
        idle(2, 1, 1);

        // RX plaintext frame held back, then drained
        for (int i = 0; i < 3; i++) cyc(1, i == 2, 8'(8'h30 + i), 0, 1, 0, 0, 0, 0);
        chk("t2Level", fifoLevel, 3);
        idle(4, 0, 1);

        // Back-to-back TX and RX frames, both sinks stalled then released
        cyc(1, 0, 8'h11, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 8'h12, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 8'h21, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 8'h22, 1, 1, 0, 0, 0, 0);
        chk("t3Level", fifoLevel, 4);
        idle(5, 1, 1);

        // Overflow: 10 bytes into 8 entries
        for (int i = 0; i < 10; i++) cyc(1, i == 9, 8'(8'h50 + i), 1, 0, 0, 0, 0, 0);
        chk("t4Level", fifoLevel, 8);
        chk("t4Ovf", overflowErr, 1);
        cyc(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        chk("t4Clr", overflowErr, 0);
        cyc(1, 1, 8'h5A, 1, 0, 0, 0, 0, 1);
        chk("t4SetWins", overflowErr, 1);
        idle(10, 1, 1);
        cyc(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);

        // Abort with 5 bytes of an open frame queued
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h70 + i), 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 1, 1, 1, 0);
        chk("t5Level", fifoLevel, 0);
        chk("t5Busy", frameBusy, 0);
        cyc(1, 1, 8'h7F, 0, 0, 0, 0, 0, 0);
        chk("t5RxRouted", rxValid, 1);
        idle(2, 1, 1);

        // Single-byte frame
        cyc(1, 1, 8'h99, 1, 0, 0, 1, 1, 0);
        chk("t6Busy", frameBusy, 0);
        chk("t6Last", txLast, 1);
        idle(3, 1, 1);

        // Random traffic with one mid-frame reset
        for (int i = 0; i < 3000; i++) begin
            bit v  = ($urandom_range(0, 9) < 7);
            bit l  = ($urandom_range(0, 3) == 0);
            bit ab = ($urandom_range(0, 63) == 0);
            bit tr = ($urandom_range(0, 2) != 0);
            bit rr = ($urandom_range(0, 2) != 0);
            bit cl = ($urandom_range(0, 15) == 0);
            if (i == 1500) doReset();
            cyc(v, l, 8'($urandom), 1'($urandom), 1'($urandom), ab, tr, rr, cl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
